// File: rtl/fetch_cycle.sv
// -----------------------------------------------------------------------------
// fetch_cycle
//   Instruction-fetch stage of a 5-stage RV32 pipeline. Owns the fetch PC,
//   runs a req/ack handshake to instruction memory and drives the IF/ID
//   pipeline register (InstrD/PCD/PCPlus4D). It copes with hazard-unit
//   stall/flush, execute-stage redirects and variable-latency memory. When no
//   instruction is ready it inserts a NOP bubble.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   StallF     hold PCF and the IF/ID register
//   FlushD     load a bubble into the IF/ID register
//   PCSrcE     taken branch/jump resolved in execute
//   PCTargetE  redirect target (low two bits ignored)
//   IMemReq    fetch request, held with a stable address until IMemAck
//   IMemAddr   word-aligned fetch address
//   IMemAck    IMemRData valid this cycle (may coincide with the rising req)
//   IMemRData  fetched instruction
//   InstrD     registered instruction to decode
//   PCD        registered PC of InstrD
//   PCPlus4D   registered PC+4 of InstrD
//   PCF        current fetch PC (debug/trace)
// -----------------------------------------------------------------------------
module fetch_cycle #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        FlushD,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemAck,
   input  logic [31:0] IMemRData,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic [31:0] PCF
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_REQ   = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pcf_q, pcf_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] redir_q, redir_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pcd_q, pcd_d;
   logic [31:0] pcplus4_q, pcplus4_d;

   logic [31:0] target;
   logic [31:0] pc_plus4;
   logic        fetch_ok;
   logic [31:0] fetch_data;

   assign target   = {PCTargetE[31:2], 2'b00};
   assign pc_plus4 = pcf_q + 32'd4;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_BOOT;
         pcf_q     <= RESET_PC;
         buf_q     <= '0;
         redir_q   <= '0;
         instr_q   <= NOP_INSTR;
         pcd_q     <= '0;
         pcplus4_q <= '0;
      end else begin
         state_q   <= state_d;
         pcf_q     <= pcf_d;
         buf_q     <= buf_d;
         redir_q   <= redir_d;
         instr_q   <= instr_d;
         pcd_q     <= pcd_d;
         pcplus4_q <= pcplus4_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      pcf_d      = pcf_q;
      buf_d      = buf_q;
      redir_d    = redir_q;
      fetch_ok   = 1'b0;
      fetch_data = IMemRData;

      case (state_q)
         ST_BOOT: begin
            state_d = ST_REQ;
            if (PCSrcE) pcf_d = target;
         end
         ST_REQ: begin
            if (IMemAck) begin
               if (PCSrcE) begin
                  pcf_d = target;            // wrong-path data, dropped
               end else if (!StallF) begin
                  fetch_ok = 1'b1;
                  pcf_d    = pc_plus4;
               end else begin
                  buf_d   = IMemRData;       // park it until the stall lifts
                  state_d = ST_HOLD;
               end
            end else if (PCSrcE) begin
               // The request cannot be withdrawn; remember where to go once
               // its (now stale) response arrives.
               redir_d = target;
               state_d = ST_DRAIN;
            end
         end
         ST_HOLD: begin
            if (PCSrcE) begin
               pcf_d   = target;
               state_d = ST_REQ;
            end else if (!StallF) begin
               fetch_ok   = 1'b1;
               fetch_data = buf_q;
               pcf_d      = pc_plus4;
               state_d    = ST_REQ;
            end
         end
         default: begin // ST_DRAIN
            if (PCSrcE) redir_d = target;    // latest redirect wins
            if (IMemAck) begin
               pcf_d   = PCSrcE ? target : redir_q;
               state_d = ST_REQ;
            end
         end
      endcase

      // IF/ID register: flush beats stall beats normal update.
      if (FlushD) begin
         instr_d   = NOP_INSTR;
         pcd_d     = '0;
         pcplus4_d = '0;
      end else if (StallF) begin
         instr_d   = instr_q;
         pcd_d     = pcd_q;
         pcplus4_d = pcplus4_q;
      end else if (fetch_ok) begin
         instr_d   = fetch_data;
         pcd_d     = pcf_q;
         pcplus4_d = pc_plus4;
      end else begin
         instr_d   = NOP_INSTR;
         pcd_d     = '0;
         pcplus4_d = '0;
      end
   end

   // Outputs. PCF only moves on an ack or outside a request, so it doubles as
   // the stable address of any outstanding request (including in DRAIN).
   always_comb begin
      IMemReq  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
      IMemAddr = pcf_q;
      InstrD   = instr_q;
      PCD      = pcd_q;
      PCPlus4D = pcplus4_q;
      PCF      = pcf_q;
   end

endmodule
